fetch_stage: RTL and testbench

- Instruction-fetch stage plus IF/ID pipeline register for the 5-stage RV32I core.
- Owns PCF and a single-outstanding-request instruction-memory handshake with variable latency.
- Applies StallF, StallD and FlushD from the hazard unit, and the EX-stage redirect (PCSrcE, PCTargetE, ALUResultE).
- Delivers InstrD/PCD/PCPlus4D/ValidD to decode, and inserts NOP bubbles whenever memory has not yet returned an instruction.

---
 rtl/fetch_stage_pkg.sv | 22 ++
 rtl/fetch_stage_if_id_reg.sv | 69 ++++++
 rtl/fetch_stage.sv | 156 +++++++++++++++
 tb/tb_fetch_stage.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/fetch_stage_pkg.sv
// Core-wide pipeline definitions shared by the fetch stage and its IF/ID register.
package fetch_stage_pkg;

  // Fetch FSM: IDLE issues a request, WAIT holds one outstanding request,
  // BUF parks a returned word while decode is stalled or flushed,
  // DROP swallows a response that belongs to a stale fetch.
  typedef enum logic [1:0] {
    FETCH_IDLE = 2'd0,
    FETCH_WAIT = 2'd1,
    FETCH_BUF  = 2'd2,
    FETCH_DROP = 2'd3
  } fetch_state_e;

  // PC source select coming from the EX stage; 2'b11 is reserved and behaves as sequential.
  localparam logic [1:0] PCSRC_SEQ  = 2'b00;
  localparam logic [1:0] PCSRC_BR   = 2'b01;
  localparam logic [1:0] PCSRC_JALR = 2'b10;

  // Bubble encoding: addi x0, x0, 0.
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register: flush beats stall, stall beats load, otherwise a bubble.
module if_id_reg #(
  parameter int          XLEN         = 32,
  parameter logic [31:0] BUBBLE_INSTR = 32'h0000_0013
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            stall,
  input  logic            load,
  input  logic [31:0]     instr_in,
  input  logic [XLEN-1:0] pc_in,
  input  logic [XLEN-1:0] pc_plus4_in,
  output logic [31:0]     instr_out,
  output logic [XLEN-1:0] pc_out,
  output logic [XLEN-1:0] pc_plus4_out,
  output logic            valid_out
);

  logic [31:0]     instr_q, instr_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] pc_plus4_q, pc_plus4_d;
  logic            valid_q, valid_d;

  // Next-state selection following flush > stall > load > bubble.
  always_comb begin
    instr_d    = BUBBLE_INSTR;
    pc_d       = '0;
    pc_plus4_d = '0;
    valid_d    = 1'b0;
    if (flush) begin
      instr_d    = BUBBLE_INSTR;
      pc_d       = '0;
      pc_plus4_d = '0;
      valid_d    = 1'b0;
    end else if (stall) begin
      instr_d    = instr_q;
      pc_d       = pc_q;
      pc_plus4_d = pc_plus4_q;
      valid_d    = valid_q;
    end else if (load) begin
      instr_d    = instr_in;
      pc_d       = pc_in;
      pc_plus4_d = pc_plus4_in;
      valid_d    = 1'b1;
    end
  end

  // Register update with synchronous active-low reset to a bubble.
  always_ff @(posedge clk) begin
    if (!rst) begin
      instr_q    <= BUBBLE_INSTR;
      pc_q       <= '0;
      pc_plus4_q <= '0;
      valid_q    <= 1'b0;
    end else begin
      instr_q    <= instr_d;
      pc_q       <= pc_d;
      pc_plus4_q <= pc_plus4_d;
      valid_q    <= valid_d;
    end
  end

  assign instr_out    = instr_q;
  assign pc_out       = pc_q;
  assign pc_plus4_out = pc_plus4_q;
  assign valid_out    = valid_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: owns PCF, a single-outstanding imem handshake, and the IF/ID register.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_PC  = '0,
  parameter logic [31:0]     NOP_INSTR = fetch_stage_pkg::NOP_INSTR
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            StallF,
  input  logic            StallD,
  input  logic            FlushD,
  input  logic [1:0]      PCSrcE,
  input  logic [XLEN-1:0] PCTargetE,
  input  logic [XLEN-1:0] ALUResultE,
  output logic            ImemReq,
  output logic [XLEN-1:0] ImemAddr,
  input  logic            ImemValid,
  input  logic [31:0]     ImemRdata,
  output logic [31:0]     InstrD,
  output logic [XLEN-1:0] PCD,
  output logic [XLEN-1:0] PCPlus4D,
  output logic            ValidD,
  output logic [XLEN-1:0] PCF
);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [31:0]     buf_instr_q, buf_instr_d;
  logic [XLEN-1:0] pc_plus4;
  logic [XLEN-1:0] redir_target;
  logic            redir;
  logic            imem_req;
  logic            deliver;
  logic [31:0]     deliver_instr;
  logic            outstanding;

  assign pc_plus4    = pc_q + XLEN'(4);
  assign outstanding = (state_q == FETCH_WAIT) || (state_q == FETCH_DROP);

  // Decode the EX-stage redirect; jalr targets always have bit 0 cleared.
  always_comb begin
    redir        = 1'b0;
    redir_target = PCTargetE;
    case (PCSrcE)
      PCSRC_BR: begin
        redir        = 1'b1;
        redir_target = PCTargetE;
      end
      PCSRC_JALR: begin
        redir        = 1'b1;
        redir_target = {ALUResultE[XLEN-1:1], 1'b0};
      end
      PCSRC_SEQ: redir = 1'b0;
      default:   redir = 1'b0;
    endcase
  end

  // Fetch FSM next state, PC update and delivery decision; PCF only moves on redirect or delivery.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    buf_instr_d   = buf_instr_q;
    imem_req      = 1'b0;
    deliver       = 1'b0;
    deliver_instr = NOP_INSTR;
    case (state_q)
      FETCH_IDLE: begin
        if (redir) begin
          pc_d = redir_target;
        end else if (!StallF) begin
          imem_req = 1'b1;
          state_d  = FETCH_WAIT;
        end
      end
      FETCH_WAIT: begin
        if (redir) begin
          pc_d    = redir_target;
          state_d = ImemValid ? FETCH_IDLE : FETCH_DROP;
        end else if (ImemValid) begin
          if (!StallD && !FlushD) begin
            deliver       = 1'b1;
            deliver_instr = ImemRdata;
            pc_d          = pc_plus4;
            state_d       = FETCH_IDLE;
          end else begin
            buf_instr_d = ImemRdata;
            state_d     = FETCH_BUF;
          end
        end
      end
      FETCH_BUF: begin
        if (redir) begin
          buf_instr_d = NOP_INSTR;
          pc_d        = redir_target;
          state_d     = FETCH_IDLE;
        end else if (!StallD && !FlushD) begin
          deliver       = 1'b1;
          deliver_instr = buf_instr_q;
          pc_d          = pc_plus4;
          state_d       = FETCH_IDLE;
        end
      end
      FETCH_DROP: begin
        if (redir) begin
          pc_d = redir_target;
        end
        if (ImemValid) begin
          state_d = FETCH_IDLE;
        end
      end
      default: state_d = FETCH_IDLE;
    endcase
  end

  // State registers; a request still in flight at reset sends the FSM to DROP so its late response is discarded.
  always_ff @(posedge clk) begin
    if (!rst) begin
      pc_q        <= RESET_PC;
      buf_instr_q <= NOP_INSTR;
      if (outstanding && !ImemValid) begin
        state_q <= FETCH_DROP;
      end else begin
        state_q <= FETCH_IDLE;
      end
    end else begin
      pc_q        <= pc_d;
      buf_instr_q <= buf_instr_d;
      state_q     <= state_d;
    end
  end

  assign ImemReq  = imem_req & rst;
  assign ImemAddr = pc_q;
  assign PCF      = pc_q;

  if_id_reg #(
    .XLEN        (XLEN),
    .BUBBLE_INSTR(NOP_INSTR)
  ) u_if_id_reg (
    .clk         (clk),
    .rst         (rst),
    .flush       (FlushD),
    .stall       (StallD),
    .load        (deliver),
    .instr_in    (deliver_instr),
    .pc_in       (pc_q),
    .pc_plus4_in (pc_plus4),
    .instr_out   (InstrD),
    .pc_out      (PCD),
    .pc_plus4_out(PCPlus4D),
    .valid_out   (ValidD)
  );

endmodule

// File: tb/tb_fetch_stage.sv
// Directed vector bench for fetch_stage: one record per clock with hand-computed expectations.
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        rst;
  logic        StallF, StallD, FlushD;
  logic [1:0]  PCSrcE;
  logic [31:0] PCTargetE, ALUResultE;
  logic        ImemReq;
  logic [31:0] ImemAddr;
  logic        ImemValid;
  logic [31:0] ImemRdata;
  logic [31:0] InstrD, PCD, PCPlus4D, PCF;
  logic        ValidD;

  int checks = 0;
  int errors = 0;
  int vec_idx = 0;

  typedef struct {
    logic        rst, stall_f, stall_d, flush_d;
    logic [1:0]  pc_src;
    logic [31:0] pc_target, alu_result;
    logic        imem_valid;
    logic [31:0] imem_rdata;
    logic        chk_addr;
    logic        exp_req;
    logic [31:0] exp_addr;
    logic [31:0] exp_pcf, exp_instr, exp_pcd;
    logic        exp_valid;
  } vec_t;

  vec_t vecs[$];

  fetch_stage dut (
    .clk       (clk),
    .rst       (rst),
    .StallF    (StallF),
    .StallD    (StallD),
    .FlushD    (FlushD),
    .PCSrcE    (PCSrcE),
    .PCTargetE (PCTargetE),
    .ALUResultE(ALUResultE),
    .ImemReq   (ImemReq),
    .ImemAddr  (ImemAddr),
    .ImemValid (ImemValid),
    .ImemRdata (ImemRdata),
    .InstrD    (InstrD),
    .PCD       (PCD),
    .PCPlus4D  (PCPlus4D),
    .ValidD    (ValidD),
    .PCF       (PCF)
  );

  // Free-running 10-unit clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input logic r, sf, sd, fd, input logic [1:0] src,
                              input logic [31:0] tgt, alu, input logic iv, input logic [31:0] rd,
                              input logic ca, input logic ereq, input logic [31:0] eaddr,
                              input logic [31:0] epcf, einstr, epcd, input logic evalid);
    vec_t v;
    v.rst = r; v.stall_f = sf; v.stall_d = sd; v.flush_d = fd;
    v.pc_src = src; v.pc_target = tgt; v.alu_result = alu;
    v.imem_valid = iv; v.imem_rdata = rd;
    v.chk_addr = ca; v.exp_req = ereq; v.exp_addr = eaddr;
    v.exp_pcf = epcf; v.exp_instr = einstr; v.exp_pcd = epcd; v.exp_valid = evalid;
    return v;
  endfunction

  task automatic checkOutput(input string what, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL vec %0d %s: got %h expected %h", idx, what, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    logic [31:0] exp_pc4;
    @(negedge clk);
    rst        = v.rst;
    StallF     = v.stall_f;
    StallD     = v.stall_d;
    FlushD     = v.flush_d;
    PCSrcE     = v.pc_src;
    PCTargetE  = v.pc_target;
    ALUResultE = v.alu_result;
    ImemValid  = v.imem_valid;
    ImemRdata  = v.imem_rdata;
    #1;
    checkOutput("ImemReq", vec_idx, {31'd0, ImemReq}, {31'd0, v.exp_req});
    if (v.chk_addr) checkOutput("ImemAddr", vec_idx, ImemAddr, v.exp_addr);
    @(posedge clk);
    #1;
    exp_pc4 = v.exp_valid ? v.exp_pcd + 32'd4 : 32'd0;
    checkOutput("PCF", vec_idx, PCF, v.exp_pcf);
    checkOutput("InstrD", vec_idx, InstrD, v.exp_instr);
    checkOutput("PCD", vec_idx, PCD, v.exp_pcd);
    checkOutput("PCPlus4D", vec_idx, PCPlus4D, exp_pc4);
    checkOutput("ValidD", vec_idx, {31'd0, ValidD}, {31'd0, v.exp_valid});
    vec_idx++;
  endtask

  // Main test: table of sequential fetch, stall/flush and redirect vectors, then multi-cycle corner sequences.
  initial begin
    rst = 1'b0; StallF = 1'b0; StallD = 1'b0; FlushD = 1'b0;
    PCSrcE = 2'b00; PCTargetE = '0; ALUResultE = '0;
    ImemValid = 1'b0; ImemRdata = '0;

    //          r sf sd fd src tgt           alu           iv rd            ca req addr          pcf           instr         pcd           v
    vecs.push_back(mk(0,0,0,0,2'd0,32'h0,       32'h0,       1,32'h0,       0,0,32'h0,       32'h0,       NOP,         32'h0,       0));
    vecs.push_back(mk(0,0,0,0,2'd0,32'h0,       32'h0,       0,32'h0,       1,0,32'h0,       32'h0,       NOP,         32'h0,       0));
    vecs.push_back(mk(1,0,0,0,2'd0,32'h0,       32'h0,       0,32'h0,       1,1,32'h0,       32'h0,       NOP,         32'h0,       0));
    vecs.push_back(mk(1,0,0,0,2'd0,32'h0,       32'h0,       1,32'h00500093,1,0,32'h0,       32'h4,       32'h00500093,32'h0,       1));
    vecs.push_back(mk(1,0,0,0,2'd0,32'h0,       32'h0,       0,32'h0,       1,1,32'h4,       32'h4,       NOP,         32'h0,       0));
    vecs.push_back(mk(1,0,0,0,2'd0,32'h0,       32'h0,       1,32'h00100113,1,0,32'h4,       32'h8,       32'h00100113,32'h4,       1));
    vecs.push_back(mk(1,0,1,0,2'd0,32'h0,       32'h0,       0,32'h0,       1,1,32'h8,       32'h8,       32'h00100113,32'h4,       1));
    vecs.push_back(mk(1,0,1,0,2'd0,32'h0,       32'h0,       1,32'hDEADBEEF,1,0,32'h8,       32'h8,       32'h00100113,32'h4,       1));
    vecs.push_back(mk(1,0,1,0,2'd0,32'h0,       32'h0,       0,32'h0,       1,0,32'h8,       32'h8,       32'h00100113,32'h4,       1));
    vecs.push_back(mk(1,0,1,0,2'd0,32'h0,       32'h0,       0,32'h0,       1,0,32'h8,       32'h8,       32'h00100113,32'h4,       1));
    vecs.push_back(mk(1,0,0,0,2'd0,32'h0,       32'h0,       0,32'h0,       1,0,32'h8,       32'hC,       32'hDEADBEEF,32'h8,       1));
    vecs.push_back(mk(1,0,1,1,2'd0,32'h0,       32'h0,       0,32'h0,       1,1,32'hC,       32'hC,       NOP,         32'h0,       0));
    vecs.push_back(mk(1,0,0,0,2'd0,32'h0,       32'h0,       0,32'h0,       1,0,32'hC,       32'hC,       NOP,         32'h0,       0));
    vecs.push_back(mk(1,0,0,1,2'd0,32'h0,       32'h0,       1,32'h00000033,1,0,32'hC,       32'hC,       NOP,         32'h0,       0));
    vecs.push_back(mk(1,0,0,0,2'd2,32'h0,       32'h00000203,0,32'h0,       1,0,32'hC,       32'h202,     NOP,         32'h0,       0));
    vecs.push_back(mk(1,0,0,0,2'd0,32'h0,       32'h0,       0,32'h0,       1,1,32'h202,     32'h202,     NOP,         32'h0,       0));
    vecs.push_back(mk(1,0,0,0,2'd0,32'h0,       32'h0,       1,32'h11111111,1,0,32'h202,     32'h206,     32'h11111111,32'h202,     1));
    vecs.push_back(mk(1,1,0,0,2'd0,32'h0,       32'h0,       0,32'h0,       1,0,32'h206,     32'h206,     NOP,         32'h0,       0));
    vecs.push_back(mk(1,1,0,0,2'd1,32'h300,     32'h0,       0,32'h0,       1,0,32'h206,     32'h300,     NOP,         32'h0,       0));
    vecs.push_back(mk(1,0,0,0,2'd3,32'h500,     32'h600,     0,32'h0,       1,1,32'h300,     32'h300,     NOP,         32'h0,       0));
    vecs.push_back(mk(1,0,0,0,2'd1,32'h400,     32'h0,       1,32'h22222222,1,0,32'h300,     32'h400,     NOP,         32'h0,       0));
    vecs.push_back(mk(1,0,0,0,2'd0,32'h0,       32'h0,       0,32'h0,       1,1,32'h400,     32'h400,     NOP,         32'h0,       0));
    vecs.push_back(mk(1,0,0,0,2'd0,32'h0,       32'h0,       1,32'h33333333,1,0,32'h400,     32'h404,     32'h33333333,32'h400,     1));
    vecs.push_back(mk(1,0,0,0,2'd1,32'hFFFFFFFC,32'h0,       0,32'h0,       1,0,32'h404,     32'hFFFFFFFC,NOP,         32'h0,       0));
    vecs.push_back(mk(1,0,0,0,2'd0,32'h0,       32'h0,       0,32'h0,       1,1,32'hFFFFFFFC,32'hFFFFFFFC,NOP,         32'h0,       0));
    vecs.push_back(mk(1,0,0,0,2'd0,32'h0,       32'h0,       1,32'h44444444,1,0,32'hFFFFFFFC,32'h0,       32'h44444444,32'hFFFFFFFC,1));
    vecs.push_back(mk(1,0,0,0,2'd0,32'h0,       32'h0,       0,32'h0,       1,1,32'h0,       32'h0,       NOP,         32'h0,       0));

    foreach (vecs[i]) applyStimulus(vecs[i]);

    // Reset with a request outstanding: first reset cycle goes to DROP, a response during reset clears it.
    applyStimulus(mk(0,0,0,0,2'd0,32'h0,  32'h0, 0,32'h0,       1,0,32'h0,  32'h0,  NOP,         32'h0,  0));
    applyStimulus(mk(0,0,0,0,2'd0,32'h0,  32'h0, 1,32'h55555555,1,0,32'h0,  32'h0,  NOP,         32'h0,  0));

    // Branch while a 4-cycle request is in flight: late response dropped, refetch from 0x100.
    applyStimulus(mk(1,0,0,0,2'd0,32'h0,  32'h0, 0,32'h0,       1,1,32'h0,  32'h0,  NOP,         32'h0,  0));
    applyStimulus(mk(1,0,0,0,2'd1,32'h100,32'h0, 0,32'h0,       1,0,32'h0,  32'h100,NOP,         32'h0,  0));
    applyStimulus(mk(1,0,0,0,2'd0,32'h0,  32'h0, 0,32'h0,       1,0,32'h100,32'h100,NOP,         32'h0,  0));
    applyStimulus(mk(1,0,0,0,2'd0,32'h0,  32'h0, 0,32'h0,       1,0,32'h100,32'h100,NOP,         32'h0,  0));
    applyStimulus(mk(1,0,0,0,2'd0,32'h0,  32'h0, 1,32'hBAD00BAD,1,0,32'h100,32'h100,NOP,         32'h0,  0));
    applyStimulus(mk(1,0,0,0,2'd0,32'h0,  32'h0, 0,32'h0,       1,1,32'h100,32'h100,NOP,         32'h0,  0));
    applyStimulus(mk(1,0,0,0,2'd0,32'h0,  32'h0, 1,32'h0AA00093,1,0,32'h100,32'h104,32'h0AA00093,32'h100,1));

    // One-cycle reset mid-WAIT: stale response swallowed, fetch restarts at RESET_PC.
    applyStimulus(mk(1,0,0,0,2'd0,32'h0,  32'h0, 0,32'h0,       1,1,32'h104,32'h104,NOP,         32'h0,  0));
    applyStimulus(mk(0,0,0,0,2'd0,32'h0,  32'h0, 0,32'h0,       1,0,32'h104,32'h0,  NOP,         32'h0,  0));
    applyStimulus(mk(1,0,0,0,2'd0,32'h0,  32'h0, 0,32'h0,       1,0,32'h0,  32'h0,  NOP,         32'h0,  0));
    applyStimulus(mk(1,0,0,0,2'd0,32'h0,  32'h0, 1,32'hBADBAD00,1,0,32'h0,  32'h0,  NOP,         32'h0,  0));
    applyStimulus(mk(1,0,0,0,2'd0,32'h0,  32'h0, 0,32'h0,       1,1,32'h0,  32'h0,  NOP,         32'h0,  0));
    applyStimulus(mk(1,0,0,0,2'd0,32'h0,  32'h0, 1,32'h01234567,1,0,32'h0,  32'h4,  32'h01234567,32'h0,  1));

    // Redirect while already in DROP moves PCF again; refetch uses the latest target.
    applyStimulus(mk(1,0,0,0,2'd0,32'h0,  32'h0, 0,32'h0,       1,1,32'h4,  32'h4,  NOP,         32'h0,  0));
    applyStimulus(mk(1,0,0,0,2'd1,32'h80, 32'h0, 0,32'h0,       1,0,32'h4,  32'h80, NOP,         32'h0,  0));
    applyStimulus(mk(1,0,0,0,2'd2,32'h0,  32'h41,0,32'h0,       1,0,32'h80, 32'h40, NOP,         32'h0,  0));
    applyStimulus(mk(1,0,0,0,2'd0,32'h0,  32'h0, 1,32'hCAFEF00D,1,0,32'h40, 32'h40, NOP,         32'h0,  0));
    applyStimulus(mk(1,0,0,0,2'd0,32'h0,  32'h0, 0,32'h0,       1,1,32'h40, 32'h40, NOP,         32'h0,  0));
    applyStimulus(mk(1,0,0,0,2'd0,32'h0,  32'h0, 1,32'h89ABCDEF,1,0,32'h40, 32'h44, 32'h89ABCDEF,32'h40, 1));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
